// File: rtl/second_largest_pkg.sv
// Shared types for the second-largest tracker.
// The update decision is named so the combinational stage reads as a small truth table.
package second_largest_pkg;

  // Outcome of comparing one new sample against the current top two values.
  typedef enum logic [1:0] {
    UPD_HOLD = 2'd0,
    UPD_SEC  = 2'd1,
    UPD_MAX  = 2'd2
  } upd_e;

endpackage : second_largest_pkg

// File: rtl/second_largest_top2_update.sv
// Combinational next-state for the (max, sec) pair given one new unsigned sample.
// A sample equal to max is not "greater", so it falls through to the sec compare.
module top2_update
  import second_largest_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] max_cur,
  input  logic [WIDTH-1:0] sec_cur,
  output logic [WIDTH-1:0] max_nxt,
  output logic [WIDTH-1:0] sec_nxt
);

  upd_e upd_s;

  // Classify the sample; a tie with max lands in sec, which counts duplicates.
  always_comb begin
    upd_s = UPD_HOLD;
    if (din > max_cur) begin
      upd_s = UPD_MAX;
    end else if (din > sec_cur) begin
      upd_s = UPD_SEC;
    end else begin
      upd_s = UPD_HOLD;
    end
  end

  // Apply the classification as a plain compare-and-load.
  always_comb begin
    max_nxt = max_cur;
    sec_nxt = sec_cur;
    case (upd_s)
      UPD_MAX: begin
        max_nxt = din;
        sec_nxt = max_cur;
      end
      UPD_SEC: begin
        max_nxt = max_cur;
        sec_nxt = din;
      end
      UPD_HOLD: begin
        max_nxt = max_cur;
        sec_nxt = sec_cur;
      end
      default: begin
        max_nxt = max_cur;
        sec_nxt = sec_cur;
      end
    endcase
  end

endmodule : top2_update

// File: rtl/second_largest.sv
// Streaming second-largest tracker: every clock edge outside reset is one sample,
// and dout presents the second-largest sample seen since the last reset.
module second_largest
  import second_largest_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] max_r;
  logic [WIDTH-1:0] sec_r;
  logic [WIDTH-1:0] max_nxt_s;
  logic [WIDTH-1:0] sec_nxt_s;

  top2_update #(
    .WIDTH (WIDTH)
  ) u_top2_update (
    .din     (din),
    .max_cur (max_r),
    .sec_cur (sec_r),
    .max_nxt (max_nxt_s),
    .sec_nxt (sec_nxt_s)
  );

  // Register stage; resetn is active-high despite its name and drops din on that edge.
  always_ff @(posedge clk) begin
    if (resetn) begin
      max_r <= {WIDTH{1'b0}};
      sec_r <= {WIDTH{1'b0}};
    end else begin
      max_r <= max_nxt_s;
      sec_r <= sec_nxt_s;
    end
  end

  assign dout = sec_r;

endmodule : second_largest

// File: tb/tb_second_largest.sv
// Directed and random self-checking bench for second_largest.
module tb_second_largest;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         resetn = 1'b1;
  logic [W-1:0] din = 16'd0;
  logic [W-1:0] dout;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] hist[$];

  always #5 clk = ~clk;

  second_largest #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .din    (din),
    .dout   (dout)
  );

  task automatic check(input string tag, input logic [W-1:0] exp);
    checks++;
    assert (dout === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, dout, exp);
    end
  endtask

  // Reset for one edge with a nonzero din that must be ignored.
  task automatic do_reset(input string tag);
    @(negedge clk);
    resetn = 1'b1;
    din    = 16'd1234;
    @(posedge clk);
    #1;
    check(tag, 16'd0);
  endtask

  task automatic sample(input logic [W-1:0] v, input logic [W-1:0] exp, input string tag);
    @(negedge clk);
    resetn = 1'b0;
    din    = v;
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  // Second largest of the whole multiset by brute force scan.
  function automatic logic [W-1:0] ref_second();
    int           mi;
    logic [W-1:0] best2;
    mi    = 0;
    best2 = 16'd0;
    if (hist.size() < 2) return 16'd0;
    for (int i = 1; i < hist.size(); i++)
      if (hist[i] > hist[mi]) mi = i;
    for (int j = 0; j < hist.size(); j++)
      if (j != mi && hist[j] > best2) best2 = hist[j];
    return best2;
  endfunction

  initial begin
    logic [W-1:0] v;
    logic [W-1:0] prev;

    // Scenario 1
    do_reset("s1_reset");
    sample(16'd3,  16'd0,  "s1_a");
    sample(16'd3,  16'd3,  "s1_dup");
    sample(16'd10, 16'd3,  "s1_c");
    sample(16'd2,  16'd3,  "s1_d");
    sample(16'd7,  16'd7,  "s1_e");
    sample(16'd20, 16'd10, "s1_f");

    // Scenario 2
    do_reset("s2_reset");
    for (int i = 0; i < 5; i++) sample(16'd0, 16'd0, "s2_zero");

    // Scenario 3
    do_reset("s3_reset");
    sample(16'hFFFF, 16'd0,    "s3_ones");
    sample(16'hFFFE, 16'hFFFE, "s3_fffe");
    sample(16'hFFFF, 16'hFFFF, "s3_ones_dup");

    // Scenario 4: mid-stream reset discards history
    do_reset("s4_reset");
    sample(16'd5, 16'd0, "s4_a");
    sample(16'd9, 16'd5, "s4_b");
    do_reset("s4_midreset");
    sample(16'd4, 16'd0, "s4_c");
    sample(16'd6, 16'd4, "s4_d");

    // Scenario 5
    do_reset("s5_reset_desc");
    sample(16'd50, 16'd0,  "s5_d1");
    sample(16'd40, 16'd40, "s5_d2");
    sample(16'd30, 16'd40, "s5_d3");
    do_reset("s5_reset_asc");
    sample(16'd1, 16'd0, "s5_a1");
    sample(16'd2, 16'd1, "s5_a2");
    sample(16'd3, 16'd2, "s5_a3");

    // Held din counts once per edge
    do_reset("hold_reset");
    sample(16'd7, 16'd0, "hold_1");
    sample(16'd7, 16'd7, "hold_2");
    sample(16'd7, 16'd7, "hold_3");

    // Scenario 6: random stream with a mix of wide, narrow and repeated values
    do_reset("s6_reset");
    hist.delete();
    prev = 16'd0;
    for (int n = 0; n < 1000; n++) begin
      case ($urandom_range(0, 3))
        0:       v = W'($urandom_range(0, 65535));
        1:       v = W'($urandom_range(0, 15));
        2:       v = prev;
        default: v = W'($urandom_range(65500, 65535));
      endcase
      prev = v;
      hist.push_back(v);
      sample(v, ref_second(), "s6_rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_second_largest
